tcu_ctrl_reg_arbiter: RTL and testbench

// Shares the single TCU register-file write port (en/wben/addr/wdata/stall) between
// the tcu_ctrl command sub-FSMs (fetch-msg, ack-msg, send/reply, ext commands).

---
 rtl/tcu_ctrl_reg_arbiter.sv | 140 ++++++++++++++
 tb/tb_tcu_ctrl_reg_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_ctrl_reg_arbiter.sv
// Round-robin arbiter sharing the TCU register-file write port between the tcu_ctrl
// sub-FSMs, with a per-grant lock for multi-write sequences and a lock watchdog.
module tcu_ctrl_reg_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int REQ_IDX_SIZE      = 2,
    parameter int LOCK_TIMEOUT      = 64,
    parameter int TCU_REG_DATA_SIZE = 32,
    parameter int TCU_REG_ADDR_SIZE = 32
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [NUM_REQ-1:0]                     req_en_i,
    input  logic [NUM_REQ-1:0]                     req_lock_i,
    input  logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0]   req_wben_i,
    input  logic [NUM_REQ*TCU_REG_ADDR_SIZE-1:0]   req_addr_i,
    input  logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]                     req_stall_o,
    output logic                                   reg_en_o,
    output logic [TCU_REG_DATA_SIZE-1:0]           reg_wben_o,
    output logic [TCU_REG_ADDR_SIZE-1:0]           reg_addr_o,
    output logic [TCU_REG_DATA_SIZE-1:0]           reg_wdata_o,
    input  logic                                   reg_stall_i,
    output logic [NUM_REQ-1:0]                     grant_o,
    output logic                                   timeout_o,
    output logic [REQ_IDX_SIZE-1:0]                timeout_idx_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q, state_d;
    logic [REQ_IDX_SIZE-1:0] grant_idx_q, grant_idx_d;
    logic [REQ_IDX_SIZE-1:0] ptr_q, ptr_d;
    logic [15:0]             wdog_q, wdog_d;
    logic                    timeout_q, timeout_d;
    logic [REQ_IDX_SIZE-1:0] timeout_idx_q, timeout_idx_d;
    logic                    active;

    // First requester strictly after 'start', wrapping modulo NUM_REQ.
    function automatic logic [REQ_IDX_SIZE-1:0] rr_pick(input logic [NUM_REQ-1:0]     req,
                                                        input logic [REQ_IDX_SIZE-1:0] start);
        logic [REQ_IDX_SIZE-1:0] win;
        logic                    found;
        int                      idx;
        win   = start;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                win   = REQ_IDX_SIZE'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            ptr_q         <= REQ_IDX_SIZE'(NUM_REQ - 1);
            wdog_q        <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            ptr_q         <= ptr_d;
            wdog_q        <= wdog_d;
            timeout_q     <= timeout_d;
            timeout_idx_q <= timeout_idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        wdog_d        = wdog_q;
        timeout_d     = 1'b0;
        timeout_idx_d = '0;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (|req_en_i) begin
                    grant_idx_d = rr_pick(req_en_i, ptr_q);
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (req_en_i[grant_idx_q]) begin
                    wdog_d = '0;
                    // A stalled write keeps the grant even when unlocked.
                    if (!reg_stall_i && !req_lock_i[grant_idx_q]) begin
                        state_d = IDLE;
                        ptr_d   = grant_idx_q;
                    end
                end else if (req_lock_i[grant_idx_q]) begin
                    if (wdog_q == 16'(LOCK_TIMEOUT - 1)) begin
                        state_d       = IDLE;
                        ptr_d         = grant_idx_q;
                        wdog_d        = '0;
                        timeout_d     = 1'b1;
                        timeout_idx_d = grant_idx_q;
                    end else begin
                        wdog_d = wdog_q + 16'd1;
                    end
                end else begin
                    state_d = IDLE;
                    ptr_d   = grant_idx_q;
                    wdog_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the port combinationally so a grant held at reset issues no write.
    assign active = (state_q == GRANT) && !reset_i;

    always_comb begin
        req_stall_o = req_en_i;
        reg_en_o    = 1'b0;
        reg_wben_o  = '0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        grant_o     = '0;
        if (active) begin
            reg_en_o                 = req_en_i[grant_idx_q];
            reg_wben_o               = req_wben_i[grant_idx_q*TCU_REG_DATA_SIZE +: TCU_REG_DATA_SIZE];
            reg_addr_o               = req_addr_i[grant_idx_q*TCU_REG_ADDR_SIZE +: TCU_REG_ADDR_SIZE];
            reg_wdata_o              = req_wdata_i[grant_idx_q*TCU_REG_DATA_SIZE +: TCU_REG_DATA_SIZE];
            req_stall_o[grant_idx_q] = reg_stall_i;
            grant_o[grant_idx_q]     = 1'b1;
        end
    end

    assign timeout_o     = timeout_q;
    assign timeout_idx_o = timeout_idx_q;

endmodule

// File: tb/tb_tcu_ctrl_reg_arbiter.sv
// Bench for tcu_ctrl_reg_arbiter: cycle table for arbitration/stall/reset, hand sequences
// for lock and watchdog, and a scoreboard checking every accepted register write.
module tb_tcu_ctrl_reg_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int LT = 8;
    localparam int D  = 32;
    localparam int A  = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_en;
    logic [N-1:0]    req_lock;
    logic [N*D-1:0]  req_wben;
    logic [N*A-1:0]  req_addr;
    logic [N*D-1:0]  req_wdata;
    logic [N-1:0]    req_stall;
    logic            reg_en;
    logic [D-1:0]    reg_wben;
    logic [A-1:0]    reg_addr;
    logic [D-1:0]    reg_wdata;
    logic            reg_stall;
    logic [N-1:0]    grant;
    logic            timeout;
    logic [IW-1:0]   timeout_idx;

    logic [A-1:0]    addr_t  [N];
    logic [D-1:0]    wdata_t [N];
    logic [D-1:0]    wben_t  [N];

    typedef struct {
        logic [A-1:0] addr;
        logic [D-1:0] wdata;
        logic [D-1:0] wben;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic         rst;
        logic [N-1:0] en;
        logic         stall;
        logic [N-1:0] grant;
        logic         reg_en;
        logic [N-1:0] req_stall;
    } vec_t;
    vec_t tbl[$];

    int n_cmp  = 0;
    int n_fail = 0;

    tcu_ctrl_reg_arbiter #(
        .NUM_REQ(N), .REQ_IDX_SIZE(IW), .LOCK_TIMEOUT(LT),
        .TCU_REG_DATA_SIZE(D), .TCU_REG_ADDR_SIZE(A)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .req_en_i(req_en), .req_lock_i(req_lock),
        .req_wben_i(req_wben), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_stall_o(req_stall),
        .reg_en_o(reg_en), .reg_wben_o(reg_wben), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
        .reg_stall_i(reg_stall),
        .grant_o(grant), .timeout_o(timeout), .timeout_idx_o(timeout_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_wben[k*D +: D]  = wben_t[k];
            req_addr[k*A +: A]  = addr_t[k];
            req_wdata[k*D +: D] = wdata_t[k];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int k);
        wr_t w;
        w.addr  = addr_t[k];
        w.wdata = wdata_t[k];
        w.wben  = wben_t[k];
        sb.push_back(w);
    endtask

    // Every write the register file accepts must match the next expected write.
    always @(negedge clk) begin
        if (reg_en === 1'b1 && reg_stall === 1'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h, required no write", reg_addr);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("sb_addr", 32'(reg_addr), 32'(w.addr));
                check("sb_wdata", reg_wdata, w.wdata);
                check("sb_wben", reg_wben, w.wben);
            end
        end
    end

    function automatic vec_t v(input logic r, input logic [N-1:0] e, input logic s,
                               input logic [N-1:0] g, input logic re, input logic [N-1:0] rs);
        vec_t x;
        x.rst = r; x.en = e; x.stall = s; x.grant = g; x.reg_en = re; x.req_stall = rs;
        return x;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] g);
        int idx;
        idx = 0;
        for (int k = 0; k < N; k++) if (g[k]) idx = k;
        return idx;
    endfunction

    // One cycle: drive after the edge, optionally expect a write, settle to the falling edge.
    task automatic cyc(input logic r, input logic [N-1:0] e, input logic [N-1:0] l,
                       input logic s, input int push);
        @(posedge clk);
        #1;
        rst = r; req_en = e; req_lock = l; reg_stall = s;
        if (push >= 0) push_wr(push);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_en = '0; req_lock = '0; reg_stall = 1'b0;
        for (int k = 0; k < N; k++) begin
            addr_t[k]  = A'(16'h0100 * (k + 1));
            wdata_t[k] = 32'hA000_0000 + 32'(k);
            wben_t[k]  = 32'hFF << (8 * k);
        end

        // reset, then simultaneous 0 and 2
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 0, 4'b0000));
        tbl.push_back(v(1, 4'b0101, 0, 4'b0000, 0, 4'b0101));
        tbl.push_back(v(0, 4'b0101, 0, 4'b0000, 0, 4'b0101));
        tbl.push_back(v(0, 4'b0101, 0, 4'b0001, 1, 4'b0100));
        tbl.push_back(v(0, 4'b0100, 0, 4'b0000, 0, 4'b0100));
        tbl.push_back(v(0, 4'b0100, 0, 4'b0100, 1, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
        // all four requesting continuously
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 0, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 0, 4'b1111));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0001, 1, 4'b1110));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 0, 4'b1111));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0010, 1, 4'b1101));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 0, 4'b1111));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0100, 1, 4'b1011));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 0, 4'b1111));
        tbl.push_back(v(0, 4'b1111, 0, 4'b1000, 1, 4'b0111));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 0, 4'b1111));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0001, 1, 4'b1110));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
        // reset during a stalled grant, pointer restarts at requester 0
        tbl.push_back(v(0, 4'b0010, 0, 4'b0000, 0, 4'b0010));
        tbl.push_back(v(0, 4'b0010, 1, 4'b0010, 1, 4'b0010));
        tbl.push_back(v(1, 4'b0010, 0, 4'b0000, 0, 4'b0010));
        tbl.push_back(v(0, 4'b0011, 0, 4'b0000, 0, 4'b0011));
        tbl.push_back(v(0, 4'b0011, 0, 4'b0001, 1, 4'b0010));
        tbl.push_back(v(0, 4'b0010, 0, 4'b0000, 0, 4'b0010));
        tbl.push_back(v(0, 4'b0010, 0, 4'b0010, 1, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
        // five stalled cycles, accepted on the sixth
        tbl.push_back(v(0, 4'b0100, 0, 4'b0000, 0, 4'b0100));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 4'b0100, 1, 4'b0100, 1, 4'b0100));
        tbl.push_back(v(0, 4'b0100, 0, 4'b0100, 1, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 4'b0000));

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].en, '0, tbl[i].stall,
                (tbl[i].reg_en && !tbl[i].stall) ? oh_idx(tbl[i].grant) : -1);
            check($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].grant));
            check($sformatf("row%0d reg_en", i), 32'(reg_en), 32'(tbl[i].reg_en));
            check($sformatf("row%0d req_stall", i), 32'(req_stall), 32'(tbl[i].req_stall));
            check($sformatf("row%0d timeout", i), 32'(timeout), 32'h0);
            if (tbl[i].reg_en)
                check($sformatf("row%0d reg_addr", i), 32'(reg_addr),
                      32'(addr_t[oh_idx(tbl[i].grant)]));
        end

        // locked two-write sequence by requester 1 while requester 3 waits
        cyc(1, 4'b0000, 4'b0000, 0, -1);
        addr_t[1] = 16'h0010;
        cyc(0, 4'b1010, 4'b0010, 0, -1);
        check("lock idle grant", 32'(grant), 32'h0);
        cyc(0, 4'b1010, 4'b0010, 0, 1);
        check("lock w1 grant", 32'(grant), 32'b0010);
        check("lock w1 addr", 32'(reg_addr), 32'h10);
        check("lock w1 stall3", 32'(req_stall), 32'b1000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'b1000, 4'b0010, 0, -1);
            check($sformatf("lock gap%0d grant", i), 32'(grant), 32'b0010);
            check($sformatf("lock gap%0d reg_en", i), 32'(reg_en), 32'h0);
            check($sformatf("lock gap%0d stall", i), 32'(req_stall), 32'b1000);
        end
        addr_t[1] = 16'h0020;
        cyc(0, 4'b1010, 4'b0010, 0, 1);
        check("lock w2 grant", 32'(grant), 32'b0010);
        check("lock w2 addr", 32'(reg_addr), 32'h20);
        cyc(0, 4'b1000, 4'b0000, 0, -1);
        check("lock drop grant", 32'(grant), 32'b0010);
        cyc(0, 4'b1000, 4'b0000, 0, -1);
        check("lock idle2 grant", 32'(grant), 32'h0);
        cyc(0, 4'b1000, 4'b0000, 0, 3);
        check("lock req3 grant", 32'(grant), 32'b1000);
        cyc(0, 4'b0000, 4'b0000, 0, -1);
        addr_t[1] = 16'h0200;

        // requester 2 holds the lock idle until the watchdog releases it
        cyc(1, 4'b0000, 4'b0000, 0, -1);
        cyc(0, 4'b0100, 4'b0100, 0, -1);
        cyc(0, 4'b0100, 4'b0100, 0, 2);
        check("wd write grant", 32'(grant), 32'b0100);
        for (int i = 0; i < LT; i++) begin
            cyc(0, 4'b0001, 4'b0100, 0, -1);
            check($sformatf("wd hold%0d grant", i), 32'(grant), 32'b0100);
            check($sformatf("wd hold%0d timeout", i), 32'(timeout), 32'h0);
        end
        cyc(0, 4'b0001, 4'b0000, 0, -1);
        check("wd fire grant", 32'(grant), 32'h0);
        check("wd fire timeout", 32'(timeout), 32'h1);
        check("wd fire idx", 32'(timeout_idx), 32'h2);
        cyc(0, 4'b0001, 4'b0000, 0, 0);
        check("wd next grant", 32'(grant), 32'b0001);
        check("wd pulse width", 32'(timeout), 32'h0);
        cyc(0, 4'b0000, 4'b0000, 0, -1);
        cyc(0, 4'b0000, 4'b0000, 0, -1);
        check("sb drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
